sram_bus_ctrl: RTL and testbench
================================

// Module: sram_bus_ctrl
// PURPOSE
//  Upstream master for the 128x8 single-bus SRAM (clk/cs/we/oe/address/data).
//  Accepts read/write requests on a valid/ready interface and sequences cs/we/oe/address.
//  Owns the write direction of the shared inout data bus and captures read data.
//  Returns one response pulse per request. Bus contention is excluded by construction.
// PARAMETERS
//  ADDR_W  7  SRAM address width (128 entries)
//  DATA_W  8  SRAM data width
// PORTS
//  clk           in     1       clock; all state changes on posedge
//  rst           in     1       reset, synchronous, active-high
//  req_valid     in     1       request present
//  req_ready     out    1       controller can accept; high only in IDLE
//  req_we        in     1       1 = write, 0 = read
//  req_addr      in     ADDR_W  request address
//  req_wdata     in     DATA_W  write data (ignored for reads)
//  rsp_valid     out    1       one-cycle completion pulse
//  rsp_we        out    1       type of the completed request
//  rsp_rdata     out    DATA_W  read data; holds last read value until next read completes
//  sram_cs       out    1       SRAM chip select
//  sram_we       out    1       SRAM write enable
//  sram_oe       out    1       SRAM output enable
//  sram_address  out    ADDR_W  SRAM address
//  sram_data     inout  DATA_W  shared bus; driven only in WR, else 'z
// BEHAVIOUR
//  - FSM states: IDLE, WR, RD_ADDR, RD_DATA; state register only, SRAM controls decoded from it.
//  - IDLE: req_ready=1, cs=we=oe=0, bus 'z. On req_valid at a posedge: latch addr/wdata/we.
//    Then go to WR if req_we=1, else to RD_ADDR.
//  - WR (1 cycle): cs=1, we=1, oe=0, bus=latched wdata. SRAM writes at the closing edge.
//    At that edge: rsp_valid<=1, rsp_we<=1; next state IDLE.
//  - RD_ADDR (1 cycle): cs=1, we=0, oe=0, bus 'z. SRAM loads its output buffer at the closing edge.
//  - RD_DATA (1 cycle): cs=0, we=0, oe=1, bus 'z (SRAM drives).
//    At the closing edge: rsp_rdata<=sram_data, rsp_valid<=1, rsp_we<=0; next state IDLE.
//  - sram_address = latched address in all states. It holds its value in IDLE.
//  - Latency, counted from the accept edge N:
//    write: memory updated at N+1; rsp_valid high in cycle N+1..N+2.
//    read: data captured at N+2; rsp_valid high in cycle N+2..N+3.
//  - Throughput: write 2 cycles/request, read 3 cycles/request, each including one IDLE cycle.
//  - The IDLE cycle guarantees a bus turnaround: oe=0 for at least one cycle before any WR drive.
//  - Invariant: bus drive enabled implies (sram_we=1 && sram_oe=0). Never oe=1 with we=0 while driving.
//  - req_valid in non-IDLE states is ignored (req_ready=0). The requester holds the request until accepted.
//  - Address 0x7F and 0x00 need no special handling; there is no wrap or auto-increment.
//  - No response backpressure: rsp_valid is a pulse and the consumer must take it.
//  - Reset (sync): at the edge with rst=1, state<=IDLE, rsp_valid<=0, rsp_we<=0, rsp_rdata<=0,
//    latched addr/wdata<=0. Outputs after that edge: req_ready=1, cs=we=oe=0, bus 'z.
//  - Reset mid-operation: the aborted request gives no response.
//    If rst is sampled during a WR cycle, the SRAM still writes at that edge, because the SRAM has no reset.
//  - rst wins over a simultaneous req_valid: the request is not accepted.
// STRUCTURE
//  - Package sram_bus_pkg: state enum (IDLE/WR/RD_ADDR/RD_DATA), ADDR_W/DATA_W defaults.
//  - Sub-module sram_bus_drv: tristate driver; inputs drive_en and dout; inout bus; output din.
//  - The FSM, request latch and response registers stay in sram_bus_ctrl.
// TESTING (bench pairs the block with the team's 128x8 single-bus SRAM model)
//  - Write 0x5A@0x12, then read 0x12: rsp_valid at N+1 (write); read rsp_rdata=0x5A 2 cycles after its accept.
//  - Write 0xA5@0x7F, write 0x3C@0x00, read both: get 0xA5 and 0x3C; req_ready low exactly in non-IDLE cycles.
//  - Back-to-back read then write with req_valid held high: exactly one IDLE cycle between oe=1 and the bus drive;
//    the contention assertion never fires.
//  - rst asserted in RD_ADDR: no rsp_valid; next cycle all controls 0, req_ready=1; a following read succeeds.
//  - req_valid toggling while busy: no extra accept; response count equals accept count over 200 random ops,
//    checked against a scoreboard.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// Shared types and default widths for the single-bus SRAM controller slice.
package sram_bus_pkg;

    localparam int unsigned SRAM_ADDR_W = 7;
    localparam int unsigned SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/sram_bus_drv.sv
// Tristate driver for the shared SRAM data bus; din always reflects the resolved bus value.
module sram_bus_drv
    import sram_bus_pkg::*;
#(
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              drive_en,
    input  logic [DATA_W-1:0] dout,
    inout  wire  [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] din
);

    assign bus = drive_en ? dout : {DATA_W{1'bz}};
    assign din = bus;

endmodule

// File: rtl/sram_bus_ctrl.sv
// Valid/ready front end for the 128x8 single-bus SRAM: sequences cs/we/oe/address,
// owns the write direction of the data bus and returns one response pulse per request.
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic              sram_oe,
    output logic [ADDR_W-1:0] sram_address,
    inout  wire  [DATA_W-1:0] sram_data
);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              drive_en;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] bus_din;

    // State register; SRAM controls are decoded from it below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control decode. The mandatory IDLE between RD_DATA and WR
    // gives the SRAM one cycle with oe low before we drive the bus.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        sram_oe   = 1'b0;
        drive_en  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_we ? WR : RD_ADDR;
                end
            end
            WR: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                drive_en  = 1'b1;
                state_nxt = IDLE;
            end
            RD_ADDR: begin
                sram_cs   = 1'b1;
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                sram_oe   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch and response registers; an aborted request never responds.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == WR) || (state == RD_DATA);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == WR) begin
                rsp_we <= 1'b1;
            end
            if (state == RD_DATA) begin
                rsp_we    <= 1'b0;
                rsp_rdata <= bus_din;
            end
        end
    end

    assign sram_address = addr_q;

    sram_bus_drv #(
        .DATA_W (DATA_W)
    ) u_drv (
        .drive_en (drive_en),
        .dout     (wdata_q),
        .bus      (sram_data),
        .din      (bus_din)
    );

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl paired with a behavioural 128x8 single-bus SRAM;
// directed cycle checks plus a random request stream against a scoreboard.
module tb_sram_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_we;
    logic [7:0] rsp_rdata;
    logic       sram_cs;
    logic       sram_we;
    logic       sram_oe;
    logic [6:0] sram_address;
    wire  [7:0] sram_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // SRAM model: write or load output buffer at posedge under cs, drive bus under oe.
    logic [7:0] mem [128];
    logic [7:0] obuf;

    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            mem[sram_address] <= sram_data;
        end else if (sram_cs && !sram_we) begin
            obuf <= mem[sram_address];
        end
    end

    assign sram_data = (sram_oe && !sram_we) ? obuf : 8'hzz;

    sram_bus_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_we       (rsp_we),
        .rsp_rdata    (rsp_rdata),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_oe      (sram_oe),
        .sram_address (sram_address),
        .sram_data    (sram_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard and protocol monitors, sampled on the falling edge.
    typedef struct {
        logic       we;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] shadow [128];
    int         acc_cnt    = 0;
    int         rsp_cnt    = 0;
    int         abort_cnt  = 0;
    int         cont_bad   = 0;
    int         ready_bad  = 0;
    int         unexp_rsp  = 0;
    logic       prev_oe    = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt++;
            if (sb_q.size() == 0) begin
                unexp_rsp++;
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rsp_we", 32'(rsp_we), 32'(e.we));
                if (!e.we) check("sb_rdata", 32'(rsp_rdata), 32'(e.rdata));
            end
        end
        if (rst) begin
            abort_cnt += sb_q.size();
            sb_q.delete();
        end else if (req_valid && req_ready) begin
            exp_t n;
            n.we    = req_we;
            n.rdata = shadow[req_addr];
            sb_q.push_back(n);
            acc_cnt++;
            if (req_we) shadow[req_addr] = req_wdata;
        end
        if (sram_oe && sram_we) cont_bad++;
        if (sram_we && prev_oe) cont_bad++;
        prev_oe = sram_oe;
        if (req_ready == (sram_cs || sram_oe)) ready_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 7'($urandom);
        req_wdata = 8'($urandom);
        @(negedge clk);
        check("wr_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h6);
        check("wr_addr", 32'(sram_address), 32'(a));
        check("wr_bus", 32'(sram_data), 32'(d));
        check("wr_rsp_early", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        check("wr_rsp", 32'({rsp_valid, rsp_we}), 32'h3);
        check("wr_idle", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        step();
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        req_addr  = 7'($urandom);
        @(negedge clk);
        check("rd_addr_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h4);
        check("rd_addr", 32'(sram_address), 32'(a));
        check("rd_rsp_early", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        check("rd_data_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h1);
        check("rd_bus", 32'(sram_data), 32'(exp));
        check("rd_rsp_early2", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        check("rd_rsp", 32'({rsp_valid, rsp_we}), 32'h2);
        check("rd_rdata", 32'(rsp_rdata), 32'(exp));
        check("rd_idle", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int cyc;
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        obuf      = 8'h00;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 7'h00;
        req_wdata = 8'h00;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        check("rst_rsp", 32'({rsp_valid, rsp_we}), 32'h0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_addr", 32'(sram_address), 32'h0);
        step();

        // Basic write then read back, and rsp_rdata holding across a write.
        do_write(7'h12, 8'h5A);
        do_read(7'h12, 8'h5A);
        do_write(7'h20, 8'h11);
        check("rdata_hold", 32'(rsp_rdata), 32'h5A);

        // Address extremes.
        do_write(7'h7F, 8'hA5);
        do_write(7'h00, 8'h3C);
        do_read(7'h7F, 8'hA5);
        do_read(7'h00, 8'h3C);

        // Read then write with req_valid held: one IDLE turnaround cycle.
        do_write(7'h30, 8'h66);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'h30;
        step();
        req_we    = 1'b1;
        req_addr  = 7'h31;
        req_wdata = 8'h99;
        @(negedge clk);
        check("b2b_rd_addr", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h4);
        step();
        @(negedge clk);
        check("b2b_rd_data", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h1);
        check("b2b_rd_bus", 32'(sram_data), 32'h66);
        step();
        @(negedge clk);
        check("b2b_turn", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        check("b2b_rd_rsp", 32'({rsp_valid, rsp_we, rsp_rdata}), 32'h266);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_wr", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h6);
        check("b2b_wr_bus", 32'(sram_data), 32'h99);
        step();
        @(negedge clk);
        check("b2b_wr_rsp", 32'({rsp_valid, rsp_we}), 32'h3);
        step();
        do_read(7'h31, 8'h99);

        // Reset during RD_ADDR aborts the read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'h12;
        step();
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("abort_rd_addr", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h4);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        check("abort_rsp", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        check("abort_rsp2", 32'(rsp_valid), 32'h0);
        step();
        do_read(7'h12, 8'h5A);

        // Reset together with req_valid: nothing is accepted.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'h12;
        req_wdata = 8'hEE;
        step();
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_wins_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        check("rst_wins_rsp", 32'(rsp_valid), 32'h0);
        step();
        do_read(7'h12, 8'h5A);

        // Reset during WR: the SRAM still takes the write, but no response.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'h40;
        req_wdata = 8'h77;
        step();
        req_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("wr_abort_rsp", 32'(rsp_valid), 32'h0);
        check("wr_abort_ctrl", 32'({req_ready, sram_cs, sram_we, sram_oe}), 32'h8);
        step();
        do_read(7'h40, 8'h77);

        // Random stream with req_valid toggling while busy.
        start = acc_cnt;
        cyc   = 0;
        while ((acc_cnt - start) < 200 && cyc < 5000) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            req_wdata = 8'($urandom);
            step();
            cyc++;
        end
        req_valid = 1'b0;
        repeat (5) step();
        check("rand_accepts", 32'(acc_cnt - start), 32'd200);
        check("rsp_count", 32'(rsp_cnt), 32'(acc_cnt - abort_cnt));
        check("aborted", 32'(abort_cnt), 32'd2);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("unexpected_rsp", 32'(unexp_rsp), 32'd0);
        check("contention", 32'(cont_bad), 32'd0);
        check("ready_vs_busy", 32'(ready_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
